y86_execute_stage: RTL and testbench

Execute stage of the pipelined Y86-64 processor. Selects ALU operands from the decoded instruction and computes valE with the 64-bit ADD/SUB/AND/XOR datapath, the same operator set as the ALU unit tests. It also maintains the condition-code register, evaluates the jXX/cmovXX condition, and registers results into the E/M pipeline register. It consumes the decode-stage outputs and feeds the memory stage.

---
 rtl/y86_execute_stage.sv | 169 ++++++++++++++++
 tb/tb_y86_execute_stage.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/y86_execute_stage.sv
// y86_execute_stage: Y86-64 execute stage.
// Selects ALU operands, computes valE, maintains the condition codes,
// evaluates the jXX/cmovXX condition and registers results into E/M.
// Optional feature macro: CC_OVERFLOW_EN (when undefined there is no OF
// flop, cc_of is tied low and conditions evaluate with OF = 0).
module y86_execute_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        e_valid,
   input  logic [3:0]  e_icode,
   input  logic [3:0]  e_ifun,
   input  logic [63:0] e_valA,
   input  logic [63:0] e_valB,
   input  logic [63:0] e_valC,
   input  logic [3:0]  e_dstE,
   input  logic [3:0]  e_dstM,
   input  logic        m_stall,
   input  logic        m_bubble,
   input  logic        set_cc_inhibit,
   output logic [63:0] e_valE_fwd,
   output logic [3:0]  e_dstE_fwd,
   output logic        M_valid,
   output logic [3:0]  M_icode,
   output logic        M_Cnd,
   output logic [63:0] M_valE,
   output logic [63:0] M_valA,
   output logic [3:0]  M_dstE,
   output logic [3:0]  M_dstM,
   output logic        cc_zf,
   output logic        cc_sf,
   output logic        cc_of
);

   localparam logic [3:0] I_NOP = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3,
                          I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_OPQ = 4'h6,
                          I_JXX = 4'h7, I_CALL = 4'h8, I_RET = 4'h9,
                          I_PUSHQ = 4'hA, I_POPQ = 4'hB;
   localparam logic [3:0] R_NONE = 4'hF;

   function automatic logic [63:0] alu_val(input logic [3:0] fn,
                                           input logic [63:0] a,
                                           input logic [63:0] b);
      case (fn)
         4'h0:    alu_val = b + a;
         4'h1:    alu_val = b - a;
         4'h2:    alu_val = b & a;
         4'h3:    alu_val = b ^ a;
         default: alu_val = 64'd0;
      endcase
   endfunction

`ifdef CC_OVERFLOW_EN
   function automatic logic alu_of(input logic [3:0] fn, input logic [63:0] a,
                                   input logic [63:0] b, input logic [63:0] v);
      case (fn)
         4'h0:    alu_of = (a[63] == b[63]) && (v[63] != a[63]);
         4'h1:    alu_of = (a[63] != b[63]) && (v[63] != b[63]);
         default: alu_of = 1'b0;
      endcase
   endfunction
`endif

   function automatic logic cond(input logic [3:0] fn, input logic zf,
                                 input logic sf, input logic of);
      case (fn)
         4'h0:    cond = 1'b1;
         4'h1:    cond = (sf ^ of) | zf;
         4'h2:    cond = sf ^ of;
         4'h3:    cond = zf;
         4'h4:    cond = ~zf;
         4'h5:    cond = ~(sf ^ of);
         4'h6:    cond = ~(sf ^ of) & ~zf;
         default: cond = 1'b0;
      endcase
   endfunction

   logic [63:0] w_aluA, w_aluB, w_valE;
   logic [3:0]  w_alufun, w_dstE;
   logic        w_cnd, w_cc_we, w_of_cur;
   logic        r_zf, r_sf;
   logic        r_vld_p1, r_cnd_p1;
   logic [3:0]  r_icode_p1, r_dstE_p1, r_dstM_p1;
   logic [63:0] r_valE_p1, r_valA_p1;

   // Stage p0: operand select, ALU, condition evaluation from current CC
   always_comb begin
      w_aluA = 64'd0;
      w_aluB = 64'd0;
      case (e_icode)
         I_RRMOVQ, I_OPQ:             w_aluA = e_valA;
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: w_aluA = e_valC;
         I_CALL, I_PUSHQ:             w_aluA = -64'sd8;
         I_RET, I_POPQ:               w_aluA = 64'd8;
         default:                     w_aluA = 64'd0;
      endcase
      case (e_icode)
         I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
         I_RET, I_PUSHQ, I_POPQ:      w_aluB = e_valB;
         default:                     w_aluB = 64'd0;
      endcase
   end

   assign w_alufun = (e_icode == I_OPQ) ? e_ifun : 4'h0;
   assign w_valE   = alu_val(w_alufun, w_aluA, w_aluB);
   assign w_cc_we  = e_valid && (e_icode == I_OPQ) && !set_cc_inhibit && !m_stall;
   assign w_cnd    = ((e_icode == I_RRMOVQ) || (e_icode == I_JXX)) ?
                     cond(e_ifun, r_zf, r_sf, w_of_cur) : 1'b0;
   assign w_dstE   = ((e_icode == I_RRMOVQ) && !w_cnd) ? R_NONE : e_dstE;

   assign e_valE_fwd = w_valE;
   assign e_dstE_fwd = w_dstE;

   // Condition-code register for zero and sign flags
   always_ff @(posedge clk) begin
      if (reset) begin
         r_zf <= 1'b1;
         r_sf <= 1'b0;
      end else if (w_cc_we) begin
         r_zf <= (w_valE == 64'd0);
         r_sf <= w_valE[63];
      end
   end

`ifdef CC_OVERFLOW_EN
   logic r_of;
   // Overflow flag, updated alongside ZF/SF
   always_ff @(posedge clk) begin
      if (reset)        r_of <= 1'b0;
      else if (w_cc_we) r_of <= alu_of(w_alufun, w_aluA, w_aluB, w_valE);
   end
   assign w_of_cur = r_of;
`else
   assign w_of_cur = 1'b0;
`endif

   assign cc_zf = r_zf;
   assign cc_sf = r_sf;
   assign cc_of = w_of_cur;

   // Stage p1: E/M register, reset > stall > bubble > load
   always_ff @(posedge clk) begin
      if (reset || (!m_stall && (m_bubble || !e_valid))) begin
         r_vld_p1   <= 1'b0;
         r_icode_p1 <= I_NOP;
         r_cnd_p1   <= 1'b0;
         r_valE_p1  <= 64'd0;
         r_valA_p1  <= 64'd0;
         r_dstE_p1  <= R_NONE;
         r_dstM_p1  <= R_NONE;
      end else if (!m_stall) begin
         r_vld_p1   <= 1'b1;
         r_icode_p1 <= e_icode;
         r_cnd_p1   <= w_cnd;
         r_valE_p1  <= w_valE;
         r_valA_p1  <= e_valA;
         r_dstE_p1  <= w_dstE;
         r_dstM_p1  <= e_dstM;
      end
   end

   assign M_valid = r_vld_p1;
   assign M_icode = r_icode_p1;
   assign M_Cnd   = r_cnd_p1;
   assign M_valE  = r_valE_p1;
   assign M_valA  = r_valA_p1;
   assign M_dstE  = r_dstE_p1;
   assign M_dstM  = r_dstM_p1;

endmodule

// File: tb/tb_y86_execute_stage.sv
// Directed, table-driven bench for y86_execute_stage.
module tb_y86_execute_stage;

`ifdef CC_OVERFLOW_EN
   localparam logic OVF = 1'b1;
`else
   localparam logic OVF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        e_valid;
   logic [3:0]  e_icode, e_ifun, e_dstE, e_dstM;
   logic [63:0] e_valA, e_valB, e_valC;
   logic        m_stall, m_bubble, set_cc_inhibit;
   logic [63:0] e_valE_fwd, M_valE, M_valA;
   logic [3:0]  e_dstE_fwd, M_icode, M_dstE, M_dstM;
   logic        M_valid, M_Cnd, cc_zf, cc_sf, cc_of;

   y86_execute_stage dut (
      .clk(clk), .reset(reset), .e_valid(e_valid), .e_icode(e_icode),
      .e_ifun(e_ifun), .e_valA(e_valA), .e_valB(e_valB), .e_valC(e_valC),
      .e_dstE(e_dstE), .e_dstM(e_dstM), .m_stall(m_stall),
      .m_bubble(m_bubble), .set_cc_inhibit(set_cc_inhibit),
      .e_valE_fwd(e_valE_fwd), .e_dstE_fwd(e_dstE_fwd), .M_valid(M_valid),
      .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA),
      .M_dstE(M_dstE), .M_dstM(M_dstM), .cc_zf(cc_zf), .cc_sf(cc_sf),
      .cc_of(cc_of)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [3:0]  icode, ifun;
      logic [63:0] valA, valB, valC;
      logic [3:0]  dstE, dstM;
      logic        stall, bubble, inh;
      logic [63:0] x_fwd_valE;
      logic [3:0]  x_fwd_dstE;
      logic        x_valid;
      logic [3:0]  x_icode;
      logic        x_cnd;
      logic [63:0] x_valE, x_valA;
      logic [3:0]  x_dstE, x_dstM;
      logic        x_zf, x_sf, x_of;
   } vec_t;

   vec_t vq[$];
   int   n_total = 0;
   int   n_pass  = 0;

   task automatic chk(input string nm, input int idx,
                      input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
   endtask

   task automatic chk_reset_state(input int idx);
      chk("rst_cc_zf", idx, 64'(cc_zf), 64'd1);
      chk("rst_cc_sf", idx, 64'(cc_sf), 64'd0);
      chk("rst_cc_of", idx, 64'(cc_of), 64'd0);
      chk("rst_M_valid", idx, 64'(M_valid), 64'd0);
      chk("rst_M_icode", idx, 64'(M_icode), 64'd1);
      chk("rst_M_Cnd", idx, 64'(M_Cnd), 64'd0);
      chk("rst_M_valE", idx, M_valE, 64'd0);
      chk("rst_M_valA", idx, M_valA, 64'd0);
      chk("rst_M_dstE", idx, 64'(M_dstE), 64'hF);
      chk("rst_M_dstM", idx, 64'(M_dstM), 64'hF);
   endtask

   task automatic drive_opq(input logic [3:0] fn, input logic [63:0] a,
                            input logic [63:0] b);
      e_valid = 1'b1; e_icode = 4'h6; e_ifun = fn;
      e_valA = a; e_valB = b; e_valC = 64'd0;
      e_dstE = 4'h3; e_dstM = 4'hF;
      m_stall = 1'b0; m_bubble = 1'b0; set_cc_inhibit = 1'b0;
   endtask

   initial begin
      //       vld ic  fn  valA                    valB                    valC     dE    dM   st   bu   in  | fwdE                   fwdD  Mv   Mic  Cnd   MvalE                   MvalA    MdE   MdM   zf   sf   of
      vq.push_back(vec_t'{1'b1,4'h6,4'h3,64'h5AA,64'hFFF,64'h0,4'h3,4'hF,1'b0,1'b0,1'b0, 64'hA55,4'h3, 1'b1,4'h6,1'b0,64'hA55,64'h5AA,4'h3,4'hF, 1'b0,1'b0,1'b0});
      vq.push_back(vec_t'{1'b1,4'h6,4'h1,64'h7,64'h7,64'h0,4'h2,4'hF,1'b0,1'b0,1'b0, 64'h0,4'h2, 1'b1,4'h6,1'b0,64'h0,64'h7,4'h2,4'hF, 1'b1,1'b0,1'b0});
      vq.push_back(vec_t'{1'b1,4'h7,4'h1,64'h40,64'h0,64'h100,4'hF,4'hF,1'b0,1'b0,1'b0, 64'h0,4'hF, 1'b1,4'h7,1'b1,64'h0,64'h40,4'hF,4'hF, 1'b1,1'b0,1'b0});
      vq.push_back(vec_t'{1'b1,4'h7,4'h6,64'h40,64'h0,64'h100,4'hF,4'hF,1'b0,1'b0,1'b0, 64'h0,4'hF, 1'b1,4'h7,1'b0,64'h0,64'h40,4'hF,4'hF, 1'b1,1'b0,1'b0});
      vq.push_back(vec_t'{1'b1,4'h7,4'h3,64'h40,64'h0,64'h100,4'hF,4'hF,1'b0,1'b0,1'b0, 64'h0,4'hF, 1'b1,4'h7,1'b1,64'h0,64'h40,4'hF,4'hF, 1'b1,1'b0,1'b0});
      vq.push_back(vec_t'{1'b1,4'h6,4'h0,64'h1,64'h7FFF_FFFF_FFFF_FFFF,64'h0,4'h4,4'hF,1'b0,1'b0,1'b0, 64'h8000_0000_0000_0000,4'h4, 1'b1,4'h6,1'b0,64'h8000_0000_0000_0000,64'h1,4'h4,4'hF, 1'b0,1'b1,OVF});
      vq.push_back(vec_t'{1'b1,4'h7,4'h2,64'h40,64'h0,64'h100,4'hF,4'hF,1'b0,1'b0,1'b0, 64'h0,4'hF, 1'b1,4'h7,!OVF,64'h0,64'h40,4'hF,4'hF, 1'b0,1'b1,OVF});
      vq.push_back(vec_t'{1'b1,4'h6,4'h2,64'hF0,64'h0F,64'h0,4'h6,4'hF,1'b0,1'b0,1'b0, 64'h0,4'h6, 1'b1,4'h6,1'b0,64'h0,64'hF0,4'h6,4'hF, 1'b1,1'b0,1'b0});
      vq.push_back(vec_t'{1'b1,4'h2,4'h4,64'h1234,64'h0,64'h0,4'h5,4'hF,1'b0,1'b0,1'b0, 64'h1234,4'hF, 1'b1,4'h2,1'b0,64'h1234,64'h1234,4'hF,4'hF, 1'b1,1'b0,1'b0});
      vq.push_back(vec_t'{1'b1,4'h2,4'h0,64'hABC,64'h0,64'h0,4'h7,4'hF,1'b0,1'b0,1'b0, 64'hABC,4'h7, 1'b1,4'h2,1'b1,64'hABC,64'hABC,4'h7,4'hF, 1'b1,1'b0,1'b0});
      vq.push_back(vec_t'{1'b1,4'h6,4'h3,64'h1,64'h0,64'h0,4'h8,4'hF,1'b1,1'b0,1'b0, 64'h1,4'h8, 1'b1,4'h2,1'b1,64'hABC,64'hABC,4'h7,4'hF, 1'b1,1'b0,1'b0});
      vq.push_back(vec_t'{1'b1,4'h6,4'h1,64'h5,64'h3,64'h0,4'h9,4'hF,1'b0,1'b0,1'b1, 64'hFFFF_FFFF_FFFF_FFFE,4'h9, 1'b1,4'h6,1'b0,64'hFFFF_FFFF_FFFF_FFFE,64'h5,4'h9,4'hF, 1'b1,1'b0,1'b0});
      vq.push_back(vec_t'{1'b1,4'h3,4'h0,64'h0,64'h0,64'h55,4'hA,4'hF,1'b1,1'b1,1'b0, 64'h55,4'hA, 1'b1,4'h6,1'b0,64'hFFFF_FFFF_FFFF_FFFE,64'h5,4'h9,4'hF, 1'b1,1'b0,1'b0});
      vq.push_back(vec_t'{1'b1,4'h3,4'h0,64'h0,64'h0,64'h55,4'hA,4'hF,1'b0,1'b1,1'b0, 64'h55,4'hA, 1'b0,4'h1,1'b0,64'h0,64'h0,4'hF,4'hF, 1'b1,1'b0,1'b0});
      vq.push_back(vec_t'{1'b1,4'h3,4'h0,64'h0,64'h0,64'h55,4'hA,4'hF,1'b0,1'b0,1'b0, 64'h55,4'hA, 1'b1,4'h3,1'b0,64'h55,64'h0,4'hA,4'hF, 1'b1,1'b0,1'b0});
      vq.push_back(vec_t'{1'b1,4'h5,4'h0,64'h0,64'h100,64'h10,4'hF,4'h3,1'b0,1'b0,1'b0, 64'h110,4'hF, 1'b1,4'h5,1'b0,64'h110,64'h0,4'hF,4'h3, 1'b1,1'b0,1'b0});
      vq.push_back(vec_t'{1'b1,4'h8,4'h0,64'h0,64'h200,64'h0,4'h4,4'hF,1'b0,1'b0,1'b0, 64'h1F8,4'h4, 1'b1,4'h8,1'b0,64'h1F8,64'h0,4'h4,4'hF, 1'b1,1'b0,1'b0});
      vq.push_back(vec_t'{1'b1,4'h9,4'h0,64'h0,64'h1F8,64'h0,4'h4,4'hF,1'b0,1'b0,1'b0, 64'h200,4'h4, 1'b1,4'h9,1'b0,64'h200,64'h0,4'h4,4'hF, 1'b1,1'b0,1'b0});
      vq.push_back(vec_t'{1'b0,4'h6,4'h0,64'h1,64'h1,64'h0,4'h2,4'hF,1'b0,1'b0,1'b0, 64'h2,4'h2, 1'b0,4'h1,1'b0,64'h0,64'h0,4'hF,4'hF, 1'b1,1'b0,1'b0});
      vq.push_back(vec_t'{1'b1,4'h6,4'h0,64'h1,64'h1,64'h0,4'h2,4'hF,1'b0,1'b0,1'b0, 64'h2,4'h2, 1'b1,4'h6,1'b0,64'h2,64'h1,4'h2,4'hF, 1'b0,1'b0,1'b0});
      vq.push_back(vec_t'{1'b1,4'h6,4'h1,64'h1,64'h8000_0000_0000_0000,64'h0,4'h2,4'hF,1'b0,1'b0,1'b0, 64'h7FFF_FFFF_FFFF_FFFF,4'h2, 1'b1,4'h6,1'b0,64'h7FFF_FFFF_FFFF_FFFF,64'h1,4'h2,4'hF, 1'b0,1'b0,OVF});
      vq.push_back(vec_t'{1'b1,4'h7,4'h5,64'h40,64'h0,64'h100,4'hF,4'hF,1'b0,1'b0,1'b0, 64'h0,4'hF, 1'b1,4'h7,!OVF,64'h0,64'h40,4'hF,4'hF, 1'b0,1'b0,OVF});
      vq.push_back(vec_t'{1'b1,4'h7,4'h4,64'h40,64'h0,64'h100,4'hF,4'hF,1'b0,1'b0,1'b0, 64'h0,4'hF, 1'b1,4'h7,1'b1,64'h0,64'h40,4'hF,4'hF, 1'b0,1'b0,OVF});
      vq.push_back(vec_t'{1'b1,4'h6,4'h5,64'h3,64'h4,64'h0,4'h2,4'hF,1'b0,1'b0,1'b0, 64'h0,4'h2, 1'b1,4'h6,1'b0,64'h0,64'h3,4'h2,4'hF, 1'b1,1'b0,1'b0});
      vq.push_back(vec_t'{1'b1,4'h7,4'h7,64'h40,64'h0,64'h100,4'hF,4'hF,1'b0,1'b0,1'b0, 64'h0,4'hF, 1'b1,4'h7,1'b0,64'h0,64'h40,4'hF,4'hF, 1'b1,1'b0,1'b0});
      vq.push_back(vec_t'{1'b1,4'h6,4'h3,64'h1,64'h8000_0000_0000_0000,64'h0,4'h1,4'hF,1'b0,1'b0,1'b0, 64'h8000_0000_0000_0001,4'h1, 1'b1,4'h6,1'b0,64'h8000_0000_0000_0001,64'h1,4'h1,4'hF, 1'b0,1'b1,1'b0});

      // Reset held one cycle with a live OPq on the inputs, which must be ignored
      reset = 1'b1;
      drive_opq(4'h3, 64'h1, 64'h0);
      @(posedge clk); #1;
      chk_reset_state(-1);

      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < vq.size(); i++) begin
         e_valid = vq[i].valid; e_icode = vq[i].icode; e_ifun = vq[i].ifun;
         e_valA = vq[i].valA; e_valB = vq[i].valB; e_valC = vq[i].valC;
         e_dstE = vq[i].dstE; e_dstM = vq[i].dstM;
         m_stall = vq[i].stall; m_bubble = vq[i].bubble;
         set_cc_inhibit = vq[i].inh;
         #1;
         chk("fwd_valE", i, e_valE_fwd, vq[i].x_fwd_valE);
         chk("fwd_dstE", i, 64'(e_dstE_fwd), 64'(vq[i].x_fwd_dstE));
         @(posedge clk); #1;
         chk("M_valid", i, 64'(M_valid), 64'(vq[i].x_valid));
         chk("M_icode", i, 64'(M_icode), 64'(vq[i].x_icode));
         chk("M_Cnd", i, 64'(M_Cnd), 64'(vq[i].x_cnd));
         chk("M_valE", i, M_valE, vq[i].x_valE);
         chk("M_valA", i, M_valA, vq[i].x_valA);
         chk("M_dstE", i, 64'(M_dstE), 64'(vq[i].x_dstE));
         chk("M_dstM", i, 64'(M_dstM), 64'(vq[i].x_dstM));
         chk("cc_zf", i, 64'(cc_zf), 64'(vq[i].x_zf));
         chk("cc_sf", i, 64'(cc_sf), 64'(vq[i].x_sf));
         chk("cc_of", i, 64'(cc_of), 64'(vq[i].x_of));
         @(negedge clk);
      end

      // Reset mid-operation, with a stall and an OPq presented at the same time
      reset = 1'b1;
      drive_opq(4'h0, 64'h3, 64'h4);
      m_stall = 1'b1;
      @(posedge clk); #1;
      chk_reset_state(100);

      // Back out of reset: first OPq loads normally
      @(negedge clk);
      reset = 1'b0;
      drive_opq(4'h0, 64'h3, 64'h4);
      #1;
      chk("post_rst_fwd", 101, e_valE_fwd, 64'h7);
      @(posedge clk); #1;
      chk("post_rst_M_valE", 101, M_valE, 64'h7);
      chk("post_rst_cc_zf", 101, 64'(cc_zf), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
